microcode_sequencer: RTL

Parametrised microcode sequencer for the 8-bit SAP-style CPU: replaces the fixed-opcode decoder with a built-in two-step fetch, a table-driven execute phase, a flags register, and conditional jumps (JC/JZ). Empty microsteps terminate the instruction early without wasted cycles. It drives the packed control word into the bus/register datapath, with program-mode, halt and debug step outputs.

---
 rtl/sap_pkg.sv | 64 ++++++
 rtl/microcode_rom.sv | 63 ++++++
 rtl/microcode_sequencer.sv | 105 ++++++++++
 3 files changed

// File: rtl/sap_pkg.sv
// Shared definitions for the SAP-style CPU microcode sequencer.
// Contents:
//   - CTRL_W and the bit index of every control line in the packed control word
//   - one-hot word constants for each control line
//   - opcode_e, the defined opcodes
//   - T0_W / T1_W, the fetch words common to every instruction
package sap_pkg;

  localparam int CTRL_W = 16;

  // Control word layout, MSB first: HLT MI RI RO IO II AI AO EO SU BI OI CE CO J FI
  localparam int HLT_B = 15;
  localparam int MI_B  = 14;
  localparam int RI_B  = 13;
  localparam int RO_B  = 12;
  localparam int IO_B  = 11;
  localparam int II_B  = 10;
  localparam int AI_B  = 9;
  localparam int AO_B  = 8;
  localparam int EO_B  = 7;
  localparam int SU_B  = 6;
  localparam int BI_B  = 5;
  localparam int OI_B  = 4;
  localparam int CE_B  = 3;
  localparam int CO_B  = 2;
  localparam int J_B   = 1;
  localparam int FI_B  = 0;

  localparam logic [CTRL_W-1:0] C_HLT = CTRL_W'(1) << HLT_B;
  localparam logic [CTRL_W-1:0] C_MI  = CTRL_W'(1) << MI_B;
  localparam logic [CTRL_W-1:0] C_RI  = CTRL_W'(1) << RI_B;
  localparam logic [CTRL_W-1:0] C_RO  = CTRL_W'(1) << RO_B;
  localparam logic [CTRL_W-1:0] C_IO  = CTRL_W'(1) << IO_B;
  localparam logic [CTRL_W-1:0] C_II  = CTRL_W'(1) << II_B;
  localparam logic [CTRL_W-1:0] C_AI  = CTRL_W'(1) << AI_B;
  localparam logic [CTRL_W-1:0] C_AO  = CTRL_W'(1) << AO_B;
  localparam logic [CTRL_W-1:0] C_EO  = CTRL_W'(1) << EO_B;
  localparam logic [CTRL_W-1:0] C_SU  = CTRL_W'(1) << SU_B;
  localparam logic [CTRL_W-1:0] C_BI  = CTRL_W'(1) << BI_B;
  localparam logic [CTRL_W-1:0] C_OI  = CTRL_W'(1) << OI_B;
  localparam logic [CTRL_W-1:0] C_CE  = CTRL_W'(1) << CE_B;
  localparam logic [CTRL_W-1:0] C_CO  = CTRL_W'(1) << CO_B;
  localparam logic [CTRL_W-1:0] C_J   = CTRL_W'(1) << J_B;
  localparam logic [CTRL_W-1:0] C_FI  = CTRL_W'(1) << FI_B;

  // Fetch: PC -> MAR, then RAM -> IR with PC increment
  localparam logic [CTRL_W-1:0] T0_W = C_CO | C_MI;
  localparam logic [CTRL_W-1:0] T1_W = C_RO | C_II | C_CE;

  typedef enum logic [3:0] {
    OP_NOP = 4'h0,
    OP_LDA = 4'h1,
    OP_ADD = 4'h2,
    OP_SUB = 4'h3,
    OP_STA = 4'h4,
    OP_LDI = 4'h5,
    OP_JMP = 4'h6,
    OP_JC  = 4'h7,
    OP_JZ  = 4'h8,
    OP_OUT = 4'hE,
    OP_HLT = 4'hF
  } opcode_e;

endpackage

// File: rtl/microcode_rom.sv
// Combinational microcode table.
// Ports:
//   opcode  in  OPC_W   : instruction opcode
//   step    in  STEP_W  : microstep being looked up
//   flag_c  in  1       : latched carry flag (selects JC)
//   flag_z  in  1       : latched zero flag (selects JZ)
//   word    out CTRL_W  : control word for (opcode, step); 0 marks an empty step
module microcode_rom
  import sap_pkg::*;
#(
  parameter int OPC_W  = 4,
  parameter int STEP_W = 3
) (
  input  logic [OPC_W-1:0]  opcode,
  input  logic [STEP_W-1:0] step,
  input  logic              flag_c,
  input  logic              flag_z,
  output logic [CTRL_W-1:0] word
);

  opcode_e op;
  assign op = opcode_e'(4'(opcode));

  always_comb begin
    word = '0;
    if (step == STEP_W'(0)) begin
      word = T0_W;
    end else if (step == STEP_W'(1)) begin
      word = T1_W;
    end else begin
      case (op)
        OP_LDA: begin
          if (step == STEP_W'(2))      word = C_IO | C_MI;
          else if (step == STEP_W'(3)) word = C_RO | C_AI;
        end
        OP_ADD: begin
          if (step == STEP_W'(2))      word = C_IO | C_MI;
          else if (step == STEP_W'(3)) word = C_RO | C_BI;
          else if (step == STEP_W'(4)) word = C_EO | C_AI | C_FI;
        end
        OP_SUB: begin
          if (step == STEP_W'(2))      word = C_IO | C_MI;
          else if (step == STEP_W'(3)) word = C_RO | C_BI;
          else if (step == STEP_W'(4)) word = C_EO | C_AI | C_SU | C_FI;
        end
        OP_STA: begin
          if (step == STEP_W'(2))      word = C_IO | C_MI;
          else if (step == STEP_W'(3)) word = C_AO | C_RI;
        end
        OP_LDI: if (step == STEP_W'(2)) word = C_IO | C_AI;
        OP_JMP: if (step == STEP_W'(2)) word = C_IO | C_J;
        // Not-taken conditional jumps leave T2 empty so the sequencer
        // restarts fetch immediately.
        OP_JC:  if (step == STEP_W'(2) && flag_c) word = C_IO | C_J;
        OP_JZ:  if (step == STEP_W'(2) && flag_z) word = C_IO | C_J;
        OP_OUT: if (step == STEP_W'(2)) word = C_AO | C_OI;
        OP_HLT: if (step == STEP_W'(2)) word = C_HLT;
        default: word = '0;
      endcase
    end
  end

endmodule

// File: rtl/microcode_sequencer.sv
// Microcode sequencer for the 8-bit SAP-style CPU. State advances on the
// falling edge of clk so the datapath can consume ctrl on the next rising edge.
// Ports:
//   clk        in  1       : system clock (falling edge active)
//   rst        in  1       : asynchronous active-high reset
//   insn       in  DATA_W  : instruction register; opcode in the top OPC_W bits
//   prog_mode  in  1       : manual RAM programming; forces HLT and step 0
//   carry_in   in  1       : ALU carry out
//   zero_in    in  1       : ALU result-is-zero
//   ctrl       out CTRL_W  : registered control word
//   step       out STEP_W  : current microstep
//   flag_c     out 1       : latched carry flag
//   flag_z     out 1       : latched zero flag
//   halted     out 1       : sticky halt status, cleared only by rst
module microcode_sequencer
  import sap_pkg::*;
#(
  parameter int DATA_W    = 8,
  parameter int OPC_W     = 4,
  parameter int NUM_STEPS = 6,
  parameter int STEP_W    = $clog2(NUM_STEPS)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [DATA_W-1:0] insn,
  input  logic              prog_mode,
  input  logic              carry_in,
  input  logic              zero_in,
  output logic [CTRL_W-1:0] ctrl,
  output logic [STEP_W-1:0] step,
  output logic              flag_c,
  output logic              flag_z,
  output logic              halted
);

  logic [OPC_W-1:0]  opcode;
  logic [CTRL_W-1:0] rom_word;
  logic [CTRL_W-1:0] ctrl_d;
  logic [STEP_W-1:0] step_d;
  logic              flag_c_d;
  logic              flag_z_d;
  logic              halted_d;
  logic              unused_operand;

  assign opcode         = insn[DATA_W-1 -: OPC_W];
  assign unused_operand = ^insn[DATA_W-OPC_W-1:0];

  microcode_rom #(
    .OPC_W  (OPC_W),
    .STEP_W (STEP_W)
  ) u_rom (
    .opcode (opcode),
    .step   (step),
    .flag_c (flag_c),
    .flag_z (flag_z),
    .word   (rom_word)
  );

  always_comb begin
    ctrl_d   = ctrl;
    step_d   = step;
    flag_c_d = flag_c;
    flag_z_d = flag_z;
    halted_d = halted;

    // The ALU result belonging to an FI word is valid one edge later.
    if (!prog_mode && ctrl[FI_B]) begin
      flag_c_d = carry_in;
      flag_z_d = zero_in;
    end

    if (prog_mode) begin
      ctrl_d = C_HLT;
      step_d = '0;
    end else if (halted) begin
      ctrl_d = C_HLT;
    end else if (step >= STEP_W'(2) && rom_word == '0) begin
      // Empty execute step: start the next fetch now, so the T0 word goes
      // out on this edge and the counter lands on T1.
      ctrl_d = T0_W;
      step_d = STEP_W'(1);
    end else begin
      ctrl_d = rom_word;
      step_d = (step == STEP_W'(NUM_STEPS-1)) ? '0 : step + STEP_W'(1);
      if (rom_word[HLT_B]) halted_d = 1'b1;
    end
  end

  always_ff @(negedge clk or posedge rst) begin
    if (rst) begin
      ctrl   <= '0;
      step   <= '0;
      flag_c <= 1'b0;
      flag_z <= 1'b0;
      halted <= 1'b0;
    end else begin
      ctrl   <= ctrl_d;
      step   <= step_d;
      flag_c <= flag_c_d;
      flag_z <= flag_z_d;
      halted <= halted_d;
    end
  end

endmodule
